// File: rtl/ram_fill_seq.sv
// Memory-initialisation sequencer: walks a single-port RAM from 0 to DEPTH-1,
// writing one pattern word per granted cycle, with abort and a completion pulse.
module ram_fill_seq #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] seed,
   input  logic              grant,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data,
   output logic              wr_en,
   output logic              task_on,
   output logic              busy,
   output logic              fin_strobe
);

   localparam int IDX_W = $clog2(DEPTH + 1);
   localparam int PW    = (DATA_W > IDX_W) ? DATA_W : IDX_W;
   localparam int AXW   = (ADDR_W > IDX_W) ? ADDR_W : IDX_W;

   if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_check
      $error("ram_fill_seq: DEPTH must be in 1..2**ADDR_W");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] seed_q;
   logic [PW-1:0]     idx_p;
   logic [PW-1:0]     pat;
   logic [AXW-1:0]    idx_a;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         mode_q <= 2'd0;
         seed_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  seed_q <= seed;
                  idx    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               // abort wins over grant: the cycle it is seen carries no write
               if (abort) begin
                  idx   <= '0;
                  state <= IDLE;
               end else if (grant) begin
                  idx <= idx + IDX_W'(1);
                  if (idx == IDX_W'(DEPTH - 1)) state <= DONE;
               end
            end
            DONE: begin
               idx   <= '0;
               state <= IDLE;
            end
            default: begin
               idx   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign task_on    = (state == RUN);
   assign busy       = (state != IDLE);
   assign fin_strobe = (state == DONE);
   assign wr_en      = (state == RUN) && grant && !abort;

   // Pattern is formed at the wider of index/data width, then cut to DATA_W.
   always_comb begin
      idx_p = PW'(idx);
      case (mode_q)
         2'd0:    pat = idx_p;
         2'd1:    pat = PW'(seed_q);
         2'd2:    pat = PW'(DEPTH - 1) - idx_p;
         default: pat = idx_p ^ PW'(seed_q);
      endcase
   end

   assign data  = pat[DATA_W-1:0];
   assign idx_a = AXW'(idx);
   assign address = idx_a[ADDR_W-1:0];

endmodule

// File: tb/tb_ram_fill_seq.sv
// Self-checking bench for ram_fill_seq: a 256-word instance and a 5-word
// instance share stimulus; writes are captured and compared to a pattern model.
module tb_ram_fill_seq;

   logic       clk = 1'b0;
   logic       rst, start, abort, grant;
   logic [1:0] mode;
   logic [7:0] seed;

   logic [7:0] address, data;
   logic       wr_en, task_on, busy, fin_strobe;
   logic [3:0] address5;
   logic [5:0] data5;
   logic       wr5, task5, busy5, fin5;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int qa[$], qd[$], qf[$], qa5[$], qd5[$], qf5[$];

   ram_fill_seq dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .seed(seed), .grant(grant), .address(address), .data(data),
      .wr_en(wr_en), .task_on(task_on), .busy(busy), .fin_strobe(fin_strobe)
   );

   ram_fill_seq #(.ADDR_W(4), .DATA_W(6), .DEPTH(5)) dut5 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .seed(seed[5:0]), .grant(grant), .address(address5), .data(data5),
      .wr_en(wr5), .task_on(task5), .busy(busy5), .fin_strobe(fin5)
   );

   always #5 clk = ~clk;

   // Reference pattern rule: word i of a DEPTH-word fill.
   function automatic int pat(int m, int i, int s, int depth);
      case (m)
         0:       return i;
         1:       return s;
         2:       return depth - 1 - i;
         default: return i ^ s;
      endcase
   endfunction

   // One clock cycle: inputs already set; outputs captured mid-cycle.
   task automatic step();
      @(negedge clk);
      if (wr_en) begin qa.push_back(int'(address)); qd.push_back(int'(data)); end
      if (fin_strobe) qf.push_back(cyc);
      if (wr5) begin qa5.push_back(int'(address5)); qd5.push_back(int'(data5)); end
      if (fin5) qf5.push_back(cyc);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_q();
      qa.delete(); qd.delete(); qf.delete();
      qa5.delete(); qd5.delete(); qf5.delete();
   endtask

   task automatic kick(input int m, input int s);
      mode = 2'(m); seed = 8'(s); start = 1'b1;
      cyc = 0; clear_q();
      step();
      start = 1'b0;
   endtask

   task automatic do_rst();
      rst = 1'b1; start = 1'b0; abort = 1'b0; grant = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; abort = 1'b0; grant = 1'b1; mode = 2'd3; seed = 8'hFF;
      step();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
      checks++; if (task_on !== 1'b0) begin errors++; $display("FAIL reset_task_on got %b want 0", task_on); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (fin_strobe !== 1'b0) begin errors++; $display("FAIL reset_fin got %b want 0", fin_strobe); end
      checks++; if (address !== 8'h00) begin errors++; $display("FAIL reset_addr got %0h want 0", address); end
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h want 0", data); end
      checks++; if ({address5, data5} !== 10'h0) begin errors++; $display("FAIL reset_dut5 got %0h want 0", {address5, data5}); end
      rst = 1'b0; start = 1'b0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_overridden got busy %b want 0", busy); end
   endtask

   task automatic test_identity();
      do_rst();
      grant = 1'b1;
      kick(0, 0);
      checks++; if (task_on !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ident_cycle1 got task_on %b busy %b want 1 1", task_on, busy); end
      for (int k = 0; k < 400 && qf.size() == 0; k++) step();
      checks++; if (qf.size() != 1 || qf[0] != 257) begin errors++; $display("FAIL ident_fin got %0d pulses first@%0d want 1@257", qf.size(), (qf.size() > 0) ? qf[0] : -1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ident_busy_258 got %b want 0", busy); end
      checks++; if (qa.size() != 256) begin errors++; $display("FAIL ident_count got %0d want 256", qa.size()); end
      for (int i = 0; i < qa.size() && i < 256; i++) begin
         checks++;
         if (qa[i] != i || qd[i] != (pat(0, i, 0, 256) & 255)) begin
            errors++; $display("FAIL ident_word%0d got (%0h,%0h) want (%0h,%0h)", i, qa[i], qd[i], i, pat(0, i, 0, 256) & 255);
         end
      end
   endtask

   task automatic test_xor_toggle();
      do_rst();
      grant = 1'b1;
      kick(3, 'hA5);
      for (int k = 0; k < 700 && qf.size() == 0; k++) begin
         grant = cyc[0];
         step();
      end
      grant = 1'b1;
      checks++; if (qf.size() != 1 || qf[0] != 512) begin errors++; $display("FAIL xor_fin got %0d pulses first@%0d want 1@512", qf.size(), (qf.size() > 0) ? qf[0] : -1); end
      checks++; if (qa.size() != 256) begin errors++; $display("FAIL xor_count got %0d want 256", qa.size()); end
      for (int i = 0; i < qa.size() && i < 256; i++) begin
         checks++;
         if (qa[i] != i || qd[i] != (pat(3, i, 'hA5, 256) & 255)) begin
            errors++; $display("FAIL xor_word%0d got (%0h,%0h) want (%0h,%0h)", i, qa[i], qd[i], i, pat(3, i, 'hA5, 256) & 255);
         end
      end
   endtask

   task automatic test_random();
      bit gpat[1300];
      int m, s, n, exp_fin;
      for (int r = 0; r < 2; r++) begin
         m = int'($urandom_range(0, 3));
         s = int'($urandom_range(0, 255));
         for (int c = 0; c < 1300; c++) gpat[c] = (c > 900) ? 1'b1 : ($urandom_range(0, 3) != 0);
         n = 0; exp_fin = 0;
         for (int c = 1; c < 1300 && n < 256; c++) begin
            if (gpat[c]) n++;
            if (n == 256) exp_fin = c + 1;
         end
         do_rst();
         kick(m, s);
         for (int k = 0; k < 1250 && qf.size() == 0; k++) begin
            grant = gpat[cyc];
            mode = 2'($urandom_range(0, 3));
            seed = 8'($urandom_range(0, 255));
            step();
         end
         checks++; if (qf.size() != 1 || qf[0] != exp_fin) begin errors++; $display("FAIL rand%0d_fin got %0d pulses first@%0d want 1@%0d", r, qf.size(), (qf.size() > 0) ? qf[0] : -1, exp_fin); end
         checks++; if (qa.size() != 256) begin errors++; $display("FAIL rand%0d_count got %0d want 256", r, qa.size()); end
         for (int i = 0; i < qa.size() && i < 256; i++) begin
            checks++;
            if (qa[i] != i || qd[i] != (pat(m, i, s, 256) & 255)) begin
               errors++; $display("FAIL rand%0d_word%0d got (%0h,%0h) want (%0h,%0h)", r, i, qa[i], qd[i], i, pat(m, i, s, 256) & 255);
            end
         end
      end
   endtask

   task automatic test_abort();
      do_rst();
      grant = 1'b1;
      kick(1, 'h3C);
      repeat (10) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++; if (task_on !== 1'b0) begin errors++; $display("FAIL abort_task_on got %b want 0", task_on); end
      repeat (5) step();
      checks++; if (qa.size() != 10) begin errors++; $display("FAIL abort_count got %0d want 10", qa.size()); end
      for (int i = 0; i < qa.size(); i++) begin
         checks++;
         if (qa[i] != i || qd[i] != 'h3C) begin errors++; $display("FAIL abort_word%0d got (%0h,%0h) want (%0h,3c)", i, qa[i], qd[i], i); end
      end
      checks++; if (qf.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got fin %0d busy %b want 0 0", qf.size(), busy); end
      kick(0, 0);
      step();
      checks++; if (qa.size() != 1 || qa[0] != 0) begin errors++; $display("FAIL abort_restart got %0d writes first %0d want 1 at 0", qa.size(), (qa.size() > 0) ? qa[0] : -1); end
   endtask

   task automatic test_depth5();
      int e5;
      do_rst();
      grant = 1'b1;
      kick(2, 0);
      for (int k = 0; k < 20 && qf5.size() == 0; k++) step();
      checks++; if (qf5.size() != 1 || qf5[0] != 6) begin errors++; $display("FAIL d5_fin got %0d pulses first@%0d want 1@6", qf5.size(), (qf5.size() > 0) ? qf5[0] : -1); end
      // back-to-back: start in the first IDLE cycle after the pulse
      mode = 2'd0; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 20 && qf5.size() < 2; k++) step();
      checks++; if (qf5.size() != 2 || qf5[1] != 13) begin errors++; $display("FAIL d5_b2b_fin got %0d pulses last@%0d want 2 last@13", qf5.size(), (qf5.size() > 0) ? qf5[qf5.size()-1] : -1); end
      checks++; if (qa5.size() != 10) begin errors++; $display("FAIL d5_count got %0d want 10", qa5.size()); end
      for (int i = 0; i < qa5.size() && i < 10; i++) begin
         e5 = (i < 5) ? pat(2, i, 0, 5) : pat(0, i - 5, 0, 5);
         checks++;
         if (qa5[i] != i % 5 || qd5[i] != (e5 & 63)) begin errors++; $display("FAIL d5_word%0d got (%0h,%0h) want (%0h,%0h)", i, qa5[i], qd5[i], i % 5, e5 & 63); end
      end
   endtask

   task automatic test_ignore();
      do_rst();
      grant = 1'b1;
      kick(0, 0);
      for (int k = 0; k < 400 && qf.size() == 0; k++) begin
         start = ((cyc >= 50 && cyc < 60) || cyc == 257);
         if (cyc == 50) begin mode = 2'd3; seed = 8'hFF; end
         step();
      end
      start = 1'b0;
      repeat (3) step();
      checks++; if (qf.size() != 1 || qf[0] != 257) begin errors++; $display("FAIL ign_fin got %0d pulses first@%0d want 1@257", qf.size(), (qf.size() > 0) ? qf[0] : -1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_not_queued got busy %b want 0", busy); end
      checks++; if (qa.size() != 256) begin errors++; $display("FAIL ign_count got %0d want 256", qa.size()); end
      for (int i = 0; i < qa.size() && i < 256; i++) begin
         checks++;
         if (qa[i] != i || qd[i] != i) begin errors++; $display("FAIL ign_word%0d got (%0h,%0h) want (%0h,%0h)", i, qa[i], qd[i], i, i); end
      end
   endtask

   task automatic test_rst_mid();
      int n;
      do_rst();
      grant = 1'b1;
      kick(3, 'h5A);
      repeat (20) step();
      rst = 1'b1;
      step();
      checks++; if ({wr_en, task_on, busy, fin_strobe} !== 4'b0) begin errors++; $display("FAIL rstmid_ctrl got %b want 0000", {wr_en, task_on, busy, fin_strobe}); end
      checks++; if (address !== 8'h0 || data !== 8'h0) begin errors++; $display("FAIL rstmid_addr_data got (%0h,%0h) want (0,0)", address, data); end
      rst = 1'b0;
      n = qa.size();
      repeat (5) step();
      checks++; if (qa.size() != n || qf.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got writes %0d fin %0d busy %b want %0d 0 0", qa.size(), qf.size(), busy, n); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; grant = 1'b0; mode = 2'd0; seed = 8'h0;
      #1;
      test_reset();
      test_identity();
      test_xor_toggle();
      test_random();
      test_abort();
      test_depth5();
      test_ignore();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
